// File: rtl/fetch_queue_unit_if.sv
// Instruction-cache request/response bus of fetch_queue_unit.
// The fetch unit is the master, the cache the slave.
interface fetch_queue_unit_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  ins_asked;
    logic [ADDR_WIDTH-1:0] ins_addr;
    logic                  ic_rdy;
    logic [31:0]           ins;

    modport master (
        output ins_asked,
        output ins_addr,
        input  ic_rdy,
        input  ins
    );

    modport slave (
        input  ins_asked,
        input  ins_addr,
        output ic_rdy,
        output ins
    );
endinterface

// File: rtl/fetch_queue_unit.sv
// Fetch front end: pre-decoding PC sequencer feeding a FIFO drained into the ROB.
// FETCH_STATIC_BTFN_EN: static backward-taken branch prediction, no predictor port.
module fetch_queue_unit #(
    parameter int                    QUEUE_DEPTH = 4,
    parameter int                    ADDR_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    fetch_queue_unit_if.master    ic,
    output logic                  ask_predictor,
    output logic [ADDR_WIDTH-1:0] pred_pc,
    input  logic                  predictor_sgn_rdy,
    input  logic                  jump,
    input  logic                  rob_full,
    input  logic                  flush,
    input  logic [ADDR_WIDTH-1:0] flush_pc,
    output logic                  if_ins_launch_flag,
    output logic [31:0]           if_ins,
    output logic [ADDR_WIDTH-1:0] if_ins_pc,
    output logic                  if_ins_pred_taken
);
    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_BR   = 7'b1100011;

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_PRED, S_HALT} state_t;

    state_t                state, state_n;
    logic [ADDR_WIDTH-1:0] pc, pc_n;
    logic                  drop_ic, drop_pred;
    logic                  push, push_tk, issue, ask, pop, full;
    logic [31:0]           br_ins, cur_ins;
    logic [ADDR_WIDTH-1:0] jimm, bimm;
    logic                  is_jal, is_jalr, is_br;
    logic                  ins_asked_q, ask_q, launch_q;
    logic [ADDR_WIDTH-1:0] ins_addr_q, pred_pc_q;
    logic [PW-1:0]         head, tail;
    logic [CW-1:0]         count;
    logic [31:0]           q_ins [QUEUE_DEPTH];
    logic [ADDR_WIDTH-1:0] q_pc  [QUEUE_DEPTH];
    logic [QUEUE_DEPTH-1:0] q_tk;

    // A branch waiting on the predictor decodes from its latched word
    assign cur_ins = (state == S_PRED) ? br_ins : ic.ins;
    assign is_jal  = cur_ins[6:0] == OP_JAL;
    assign is_jalr = cur_ins[6:0] == OP_JALR;
    assign is_br   = cur_ins[6:0] == OP_BR;
    assign jimm = {{(ADDR_WIDTH-20){cur_ins[31]}}, cur_ins[19:12],
                   cur_ins[20], cur_ins[30:21], 1'b0};
    assign bimm = {{(ADDR_WIDTH-12){cur_ins[31]}}, cur_ins[7],
                   cur_ins[30:25], cur_ins[11:8], 1'b0};

    assign full = count == CW'(QUEUE_DEPTH);
    assign pop  = (count != '0) && !rob_full && !flush;

    always_comb begin
        state_n = state;
        pc_n    = pc;
        push    = 1'b0;
        push_tk = 1'b0;
        issue   = 1'b0;
        ask     = 1'b0;
        unique case (state)
            S_REQ: begin
                if (!drop_ic && !full) begin
                    issue   = 1'b1;
                    state_n = S_WAIT;
                end
            end
            S_WAIT: begin
                if (ic.ic_rdy && !drop_ic) begin
                    unique case (1'b1)
                        is_jal: begin
                            push    = 1'b1;
                            push_tk = 1'b1;
                            pc_n    = pc + jimm;
                            state_n = S_REQ;
                        end
                        is_br: begin
`ifdef FETCH_STATIC_BTFN_EN
                            push    = 1'b1;
                            push_tk = bimm[ADDR_WIDTH-1];
                            pc_n    = push_tk ? pc + bimm : pc + ADDR_WIDTH'(4);
                            state_n = S_REQ;
`else
                            ask     = 1'b1;
                            state_n = S_PRED;
`endif
                        end
                        is_jalr: begin
                            push    = 1'b1;
                            state_n = S_HALT;
                        end
                        default: begin
                            push    = 1'b1;
                            pc_n    = pc + ADDR_WIDTH'(4);
                            state_n = S_REQ;
                        end
                    endcase
                end
            end
            S_PRED: begin
                if (predictor_sgn_rdy && !drop_pred) begin
                    push    = 1'b1;
                    push_tk = jump;
                    pc_n    = jump ? pc + bimm : pc + ADDR_WIDTH'(4);
                    state_n = S_REQ;
                end
            end
            default: ;
        endcase
        if (flush) begin
            state_n = S_REQ;
            pc_n    = flush_pc;
            push    = 1'b0;
            issue   = 1'b0;
            ask     = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_REQ;
        else if (rdy)
            state <= state_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc                <= RESET_PC;
            drop_ic           <= 1'b0;
            drop_pred         <= 1'b0;
            br_ins            <= '0;
            ins_asked_q       <= 1'b0;
            ins_addr_q        <= RESET_PC;
            ask_q             <= 1'b0;
            pred_pc_q         <= '0;
            launch_q          <= 1'b0;
            if_ins            <= '0;
            if_ins_pc         <= '0;
            if_ins_pred_taken <= 1'b0;
            head              <= '0;
            tail              <= '0;
            count             <= '0;
        end else if (!rdy) begin
            ins_asked_q <= 1'b0;
            ask_q       <= 1'b0;
            launch_q    <= 1'b0;
        end else begin
            pc <= pc_n;
            // A flushed request still owes one response; swallow it
            drop_ic   <= (drop_ic || (flush && state == S_WAIT)) && !ic.ic_rdy;
            drop_pred <= (drop_pred || (flush && state == S_PRED))
                         && !predictor_sgn_rdy;
            ins_asked_q <= issue;
            ask_q       <= ask;
            launch_q    <= pop;
            if (issue)
                ins_addr_q <= pc;
            if (ask) begin
                pred_pc_q <= pc;
                br_ins    <= ic.ins;
            end
            if (pop) begin
                if_ins            <= q_ins[head];
                if_ins_pc         <= q_pc[head];
                if_ins_pred_taken <= q_tk[head];
            end
            if (flush) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (pop)
                    head <= head + PW'(1);
                if (push)
                    tail <= tail + PW'(1);
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rdy && push) begin
            q_ins[tail] <= cur_ins;
            q_pc[tail]  <= pc;
            q_tk[tail]  <= push_tk;
        end
    end

    assign ic.ins_asked         = ins_asked_q;
    assign ic.ins_addr          = ins_addr_q;
    assign if_ins_launch_flag   = launch_q;
`ifdef FETCH_STATIC_BTFN_EN
    assign ask_predictor = 1'b0;
    assign pred_pc       = '0;
`else
    assign ask_predictor = ask_q;
    assign pred_pc       = pred_pc_q;
`endif
endmodule
